// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 streaming multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Bit offset of channel k inside a packed {ch[N-1], ..., ch[0]} bus.
  function automatic int chan_lo(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after `last`,
// wrapping from N_CH-1 back to 0.
module rr_arbiter #(
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  int unsigned idx;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    // Offset 1..N_CH visits every channel once, ending on `last` itself.
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last) + i) % N_CH;
      if (!gnt_valid && req[SEL_W'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_1_seq.sv
// N-channel registered multiplexer with valid/ready on every channel and on
// the output; fixed-select or round-robin channel choice.
module mux_n_1_seq
  import mux_pkg::*;
#(
  parameter  int N_CH   = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. Producers hold valid and data stable until that edge. in_ready
  // depends combinationally on in_valid, mode, sel and out_ready.

  logic [DATA_W-1:0] ch_data [N_CH];
  logic [SEL_W-1:0]  last_q, last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;

  logic [SEL_W-1:0]  rr_idx;
  logic              rr_valid;
  logic [SEL_W-1:0]  g_idx;
  logic              g_valid;
  logic              ld;
  logic              accept;

  for (genvar k = 0; k < N_CH; k++) begin : g_slice
    assign ch_data[k] = in_data[chan_lo(k, DATA_W) +: DATA_W];
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (in_valid),
    .last      (last_q),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  always_comb begin
    g_idx   = '0;
    g_valid = 1'b0;
    if (mode == MODE_RR) begin
      g_idx   = rr_idx;
      g_valid = rr_valid;
    end else begin
      // Out-of-range selects (non-power-of-two N_CH) never win a grant.
      g_idx   = sel;
      g_valid = (int'(sel) < N_CH) && in_valid[sel];
    end
  end

  assign ld       = !out_valid_q || out_ready;
  assign accept   = ld && g_valid && !rst;
  assign in_ready = accept ? (N_CH'(1) << g_idx) : '0;

  always_comb begin
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (ld) begin
      out_valid_d = g_valid;
      if (g_valid) begin
        out_data_d = ch_data[g_idx];
        out_ch_d   = g_idx;
        last_d     = g_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= SEL_W'(N_CH - 1);
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_1_seq.sv
// Directed bench for mux_n_1_seq with N_CH=8, DATA_W=8.
module tb_mux_n_1_seq;

  localparam int N_CH   = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  logic                   clk;
  logic                   rst;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_valid;
  logic                   out_ready;

  int checks;
  int failures;
  int acc_cnt [N_CH];

  mux_n_1_seq #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] ch, input logic [7:0] d);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".ch"},    64'(out_ch),    64'(ch));
    chk({tag, ".data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    logic [7:0] onehot;
    checks   = 0;
    failures = 0;
    for (int k = 0; k < N_CH; k++) acc_cnt[k] = 0;
    for (int k = 0; k < N_CH; k++) in_data[k*DATA_W +: DATA_W] = 8'h10 + 8'(k);
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;

    // Reset then idle
    step();
    chk_out("rst1", 1'b0, 3'd0, 8'h00);
    chk("rst1.in_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("rst2", 1'b0, 3'd0, 8'h00);
    in_valid = 8'hFF;
    #1 chk("rst_valid.in_ready", 64'(in_ready), 64'h0);
    rst = 1'b0; in_valid = '0;
    step();
    chk_out("idle", 1'b0, 3'd0, 8'h00);
    chk("idle.in_ready", 64'(in_ready), 64'h0);

    // Fixed select over every channel
    mode = 1'b0; in_valid = 8'hFF;
    for (int s = 0; s < N_CH; s++) begin
      sel = 3'(s);
      onehot = 8'h01 << s;
      #1 chk($sformatf("fix%0d.in_ready", s), 64'(in_ready), 64'(onehot));
      step();
      chk_out($sformatf("fix%0d", s), 1'b1, 3'(s), 8'h10 + 8'(s));
    end

    // Fixed select on an idle channel: no grant, output drains
    sel = 3'd3; in_valid = 8'b0000_0100;
    #1 chk("fix_idle.in_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("fix_idle", 1'b0, 3'd7, 8'h17);

    // Round-robin fairness, all channels requesting
    mode = 1'b1; in_valid = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      onehot = 8'h01 << (i % 8);
      #1 chk($sformatf("rr%0d.in_ready", i), 64'(in_ready), 64'(onehot));
      for (int k = 0; k < N_CH; k++) if (in_ready[k] && in_valid[k]) acc_cnt[k]++;
      step();
      chk_out($sformatf("rr%0d", i), 1'b1, 3'(i % 8), 8'h10 + 8'(i % 8));
    end
    for (int k = 0; k < N_CH; k++) chk($sformatf("rr_count%0d", k), 64'(acc_cnt[k]), 64'd2);

    // Sparse requesters with wrap: 1,7,1,7
    in_valid = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("sparse%0d", i), 1'b1, (i % 2 == 0) ? 3'd1 : 3'd7,
              (i % 2 == 0) ? 8'h11 : 8'h17);
    end

    // Backpressure: load ch2 = A5, stall 3 cycles, then ch4 with no bubble
    in_data[2*DATA_W +: DATA_W] = 8'hA5;
    in_data[4*DATA_W +: DATA_W] = 8'h3C;
    in_valid = 8'b0000_0100;
    step();
    chk_out("bp_load", 1'b1, 3'd2, 8'hA5);
    out_ready = 1'b0; in_valid = 8'b0001_0100;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin mode = 1'b0; sel = 3'd6; end
      if (i == 2) mode = 1'b1;
      #1 chk($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'h0);
      step();
      chk_out($sformatf("bp%0d", i), 1'b1, 3'd2, 8'hA5);
    end
    out_ready = 1'b1;
    #1 chk("bp_release.in_ready", 64'(in_ready), 64'b0001_0000);
    step();
    chk_out("bp_release", 1'b1, 3'd4, 8'h3C);

    // Mid-stream reset while stalled; pointer must restart before channel 0
    out_ready = 1'b0; in_valid = 8'b0101_0000;
    step();
    chk_out("pre_rst", 1'b1, 3'd4, 8'h3C);
    rst = 1'b1;
    #1 chk("mid_rst.in_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("mid_rst", 1'b0, 3'd0, 8'h00);
    rst = 1'b0; out_ready = 1'b1; in_valid = 8'b0100_0100;
    #1 chk("post_rst.in_ready", 64'(in_ready), 64'b0000_0100);
    step();
    chk_out("post_rst", 1'b1, 3'd2, 8'hA5);

    // Drain: data and channel hold, valid drops
    in_valid = '0;
    #1 chk("drain.in_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("drain", 1'b0, 3'd2, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_1_seq.md
Name: mux_n_1_seq

Overview:
Parametrised N-channel, W-bit registered multiplexer. It is the streaming successor of the team's fixed 8:1 single-bit structural mux. Each input channel and the single output carry a valid/ready handshake. Two selection modes: fixed select (driven by `sel`) and round-robin among valid channels. Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 8, number of input channels (2..32).
- DATA_W, 8, bits per channel.
- SEL_W, $clog2(N_CH), derived localparam; width of `sel` and `out_ch`.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = MODE_FIXED, 1 = MODE_RR.
- sel  in  SEL_W  channel index, used in MODE_FIXED only.
- in_data  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready (combinational).
- out_data  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  registered index of the source channel.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer last=N_CH-1, so channel 0 has first priority.
  - in_ready is all-zero while rst=1.
- Load enable: `ld = !out_valid || out_ready`. The output stage is a single register, giving full throughput of 1 transfer/cycle.
- Grant (combinational, same cycle):
  - MODE_FIXED: g=sel. The grant is valid iff sel<N_CH and in_valid[sel].
  - MODE_RR: g = first k with in_valid[k]=1, searching (last+1) mod N_CH upward with wrap. The grant is valid iff any in_valid bit is set.
- in_ready[k] = ld && grant_valid && (k==g). At most one bit is set. No ready is asserted to a non-granted channel.
- On a clk edge with ld=1:
  - If grant_valid: out_data<=in_data[g], out_ch<=g, out_valid<=1.
  - Else: out_valid<=0, and out_data/out_ch hold their values.
- With ld=0 (out_valid && !out_ready): out_data, out_ch and out_valid hold. in_ready is all-zero.
- RR pointer update: last<=g on every accepted input transfer (in_valid[g] && in_ready[g]), in either mode. This keeps RR fairness continuous after a mode switch.
- Latency: input transfer to out_valid is exactly 1 cycle. Back-to-back transfers run with no bubbles while out_ready=1.
- Boundaries:
  - All in_valid=0: no grant. Output drains on the next ld edge.
  - Single requester in RR mode: granted every cycle.
  - Pointer wrap: last=N_CH-1 searches from channel 0.
  - sel>=N_CH (non-power-of-2 N_CH): never granted, no ready asserted.
  - mode or sel changes while the output is stalled: the held output is unaffected. The new selection applies to the next load.
  - rst asserted mid-stream: any pending output is discarded, and the pointer returns to N_CH-1.
- Inputs must obey the standard valid/ready rule: once valid is asserted, data is held until accepted. The block does not check this.

Decomposition:
- Package `mux_pkg`:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - Function for channel-slice extraction.
- Sub-module `rr_arbiter`:
  - Parameter: N_CH.
  - Inputs: req[N_CH], last[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_valid.
  - Purely combinational and reusable.
- Top `mux_n_1_seq` contains: the fixed/RR grant select, the ready decode, the output register and the pointer register.

Test Plan:
- Reset then idle: rst high 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout.
- Fixed mode, N_CH=8, DATA_W=8: in_data[k]=8'h10+k, all valid, sel=5, out_ready=1 -> in_ready=8'b0010_0000. Next cycle out_data=8'h15, out_ch=5, out_valid=1. Repeat for every sel 0..7.
- RR fairness: all 8 valid, out_ready=1 for 16 cycles -> out_ch sequence 0,1,...,7,0,...,7 with no gaps. Each channel is accepted exactly twice.
- RR sparse/wrap: in_valid=8'b1000_0010, last=1 after the first grant -> grants 1,7,1,7. out_ch alternates and the wrap from 7 to 1 is correct.
- Backpressure: out_ready=0 for 3 cycles after a load of ch2 data 8'hA5 -> out_data holds 8'hA5, out_ch=2, in_ready=0. Then out_ready=1 -> next grant loads in the same cycle, with no bubble.
- Mid-stream reset: rst pulsed while out_valid=1 and stalled -> next cycle out_valid=0. The first RR grant after reset is the lowest valid channel starting from 0.
